// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC sample FIFO: channel map, register bit positions
// and the STATUS word layout.
package fsmc_pkg;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned CH_DATA   = 0;
    localparam int unsigned CH_STATUS = 1;
    localparam int unsigned CH_CTRL   = 2;
    localparam int unsigned CH_THRESH = 3;

    localparam int unsigned ST_OVERFLOW  = 15;
    localparam int unsigned ST_UNDERFLOW = 14;
    localparam int unsigned ST_FULL      = 13;
    localparam int unsigned ST_EMPTY     = 12;
    localparam int unsigned ST_IRQ       = 11;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_CLEAR  = 1;

    localparam int unsigned CNT_W = 11;

    // Field order gives the MSB-first STATUS layout.
    typedef struct packed {
        logic             overflow;
        logic             underflow;
        logic             full;
        logic             empty;
        logic             irq;
        logic [CNT_W-1:0] count;
    } status_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Dual-pointer FIFO storage with occupancy count and a registered head word.
// A pop while empty is ignored; a push while full succeeds only alongside a pop.
module sync_fifo_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_ptr, wr_ptr, rd_next;
    logic                  do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            // The slot written this cycle is not yet in mem, so forward it.
            head <= (do_push && (rd_next == wr_ptr)) ? wdata : mem[rd_next];
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fsmc_sample_fifo.sv
// Sample FIFO exposed through four FSMC channels: DATA, STATUS, CTRL, THRESH.
// Define FSMC_FIFO_IRQ_EN to enable the THRESH register and the level interrupt.
module fsmc_sample_fifo
    import fsmc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned CS_WIDTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_valid,
    input  logic [2**CS_WIDTH-1:0]   bus_cs,
    input  logic                     bus_state,
    input  logic [DATA_WIDTH-1:0]    bus_wdata,
    output logic [DATA_WIDTH-1:0]    bus_rdata,
    output logic                     irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [2**CS_WIDTH-1:0] cs_q, cs_fell;
    logic                   rd_done, wr_done, pop, push;
    logic                   enable_q, flush_q, overflow_q, underflow_q, irq_int;
    logic [CW-1:0]          count;
    logic                   full, empty;
    logic [DATA_WIDTH-1:0]  head, rdata_d, thresh_word;
    status_t                status;
    logic                   unused_wdata;

    assign cs_fell = cs_q & ~bus_cs;
    assign rd_done = (|cs_fell) && bus_state;
    assign wr_done = (|cs_fell) && !bus_state;
    assign pop     = rd_done && cs_fell[CH_DATA];
    assign push    = s_valid && enable_q && !flush_q;

    assign unused_wdata = ^bus_wdata;

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .flush (flush_q),
        .push  (push),
        .pop   (pop),
        .wdata (s_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_q        <= '0;
            enable_q    <= 1'b0;
            flush_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            bus_rdata   <= '0;
        end else begin
            cs_q      <= bus_cs;
            bus_rdata <= rdata_d;
            flush_q   <= wr_done && cs_fell[CH_CTRL] && bus_wdata[CTRL_CLEAR];
            if (wr_done && cs_fell[CH_CTRL]) begin
                enable_q <= bus_wdata[CTRL_ENABLE];
            end
            if (flush_q) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                if (push && full && !pop) overflow_q  <= 1'b1;
                if (pop && empty)         underflow_q <= 1'b1;
            end
        end
    end

`ifdef FSMC_FIFO_IRQ_EN
    logic [CNT_W-1:0] thresh_q;
    logic             irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_done && cs_fell[CH_THRESH]) begin
                thresh_q <= bus_wdata[CNT_W-1:0];
            end
            irq_q <= enable_q && (thresh_q != '0) && (CNT_W'(count) >= thresh_q);
        end
    end

    assign irq_int     = irq_q;
    assign thresh_word = DATA_WIDTH'(thresh_q);
`else
    assign irq_int     = 1'b0;
    assign thresh_word = '0;
`endif

    assign irq = irq_int;

    always_comb begin
        status.overflow  = overflow_q;
        status.underflow = underflow_q;
        status.full      = full;
        status.empty     = empty;
        status.irq       = irq_int;
        status.count     = CNT_W'(count);

        rdata_d = '0;
        if (bus_cs[CH_DATA]) begin
            rdata_d = empty ? '0 : head;
        end else if (bus_cs[CH_STATUS]) begin
            rdata_d = DATA_WIDTH'(status);
        end else if (bus_cs[CH_CTRL]) begin
            rdata_d[CTRL_ENABLE] = enable_q;
        end else if (bus_cs[CH_THRESH]) begin
            rdata_d = thresh_word;
        end
    end

endmodule

// File: tb/tb_fsmc_sample_fifo.sv
// Directed bench for fsmc_sample_fifo: a default-depth instance and a DEPTH=4 instance
// share one stimulus stream; FSMC_FIFO_IRQ_EN selects the interrupt checks.
module tb_fsmc_sample_fifo;

    localparam int CH_DATA = 0, CH_STATUS = 1, CH_CTRL = 2, CH_THRESH = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic [3:0]  bus_cs;
    logic        bus_state;
    logic [15:0] bus_wdata;
    logic [15:0] rdata, rdata4;
    logic        irq, irq4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsmc_sample_fifo dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .bus_cs    (bus_cs),
        .bus_state (bus_state),
        .bus_wdata (bus_wdata),
        .bus_rdata (rdata),
        .irq       (irq)
    );

    fsmc_sample_fifo #(
        .DEPTH (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .bus_cs    (bus_cs),
        .bus_state (bus_state),
        .bus_wdata (bus_wdata),
        .bus_rdata (rdata4),
        .irq       (irq4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic bus_write(input int ch, input logic [15:0] d);
        bus_cs    = 4'(1 << ch);
        bus_state = 1'b0;
        bus_wdata = d;
        tick();
        bus_cs = '0;
        tick();
    endtask

    // Holds the select two cycles so a clear committed just before is already visible.
    task automatic bus_read(input int ch, output logic [15:0] d, output logic [15:0] d4);
        bus_cs    = 4'(1 << ch);
        bus_state = 1'b1;
        tick();
        tick();
        d  = rdata;
        d4 = rdata4;
        bus_cs = '0;
        tick();
    endtask

    logic [15:0] r, r4;

    initial begin
        reset = 1'b1; s_data = '0; s_valid = 1'b0;
        bus_cs = '0; bus_state = 1'b0; bus_wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("reset_rdata", rdata, 16'h0000);
        check("reset_irq", irq, 1'b0);
        check("reset_rdata4", rdata4, 16'h0000);
        bus_read(CH_STATUS, r, r4);
        check("reset_status", r, 16'h1000);
        check("reset_status4", r4, 16'h1000);

        bus_write(CH_CTRL, 16'h0001);
        bus_read(CH_CTRL, r, r4);
        check("ctrl_enable", r, 16'h0001);

        // Fill and drain.
        for (int i = 1; i <= 5; i++) push(16'(i));
        bus_read(CH_STATUS, r, r4);
        check("fill_status", r, 16'h0005);
        check("fill_status4_ovf", r4, 16'hA004);
        for (int i = 1; i <= 5; i++) begin
            bus_read(CH_DATA, r, r4);
            check($sformatf("drain_%0d", i), r, 32'(i));
        end
        bus_read(CH_STATUS, r, r4);
        check("drain_status", r, 16'h1000);

        // Underflow.
        bus_read(CH_DATA, r, r4);
        check("udf_data", r, 16'h0000);
        bus_read(CH_STATUS, r, r4);
        check("udf_status", r, 16'h5000);
        check("udf_status4", r4, 16'hD000);

        // Disabled input is ignored.
        bus_write(CH_CTRL, 16'h0000);
        push(16'h0077);
        bus_read(CH_STATUS, r, r4);
        check("disabled_status", r, 16'h5000);

        bus_write(CH_CTRL, 16'h0003);
        bus_read(CH_STATUS, r, r4);
        check("clear1_status", r, 16'h1000);
        check("clear1_status4", r4, 16'h1000);
        bus_read(CH_CTRL, r, r4);
        check("clear1_ctrl", r, 16'h0001);

        // Overflow on the DEPTH=4 instance.
        for (int i = 1; i <= 6; i++) push(16'(16'h10 + i));
        bus_read(CH_STATUS, r, r4);
        check("ovf_status4", r4, 16'hA004);
        check("ovf_status_big", r, 16'h0006);
        for (int i = 1; i <= 4; i++) begin
            bus_read(CH_DATA, r, r4);
            check($sformatf("ovf_data_%0d", i), r4, 32'(16'h10 + i));
        end

        // Clear with overflow set and count 3.
        for (int i = 1; i <= 3; i++) push(16'(16'h30 + i));
        bus_read(CH_STATUS, r, r4);
        check("preclear_status4", r4, 16'h8003);
        bus_write(CH_CTRL, 16'h0003);
        bus_read(CH_STATUS, r, r4);
        check("clear2_status4", r4, 16'h1000);
        check("clear2_status", r, 16'h1000);
        bus_read(CH_CTRL, r, r4);
        check("clear2_ctrl4", r4, 16'h0001);

        // Full FIFO with a push on the pop-completion cycle.
        for (int i = 1; i <= 4; i++) push(16'(16'h20 + i));
        bus_read(CH_STATUS, r, r4);
        check("full_status4", r4, 16'h2004);
        bus_cs = 4'b0001; bus_state = 1'b1;
        tick();
        tick();
        check("fullpop_data4", rdata4, 16'h0021);
        bus_cs = '0; s_data = 16'hAAAA; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        bus_read(CH_STATUS, r, r4);
        check("fullpop_status4", r4, 16'h2004);
        for (int i = 2; i <= 4; i++) begin
            bus_read(CH_DATA, r, r4);
            check($sformatf("fullpop_data_%0d", i), r4, 32'(16'h20 + i));
        end
        bus_read(CH_DATA, r, r4);
        check("fullpop_last", r4, 16'hAAAA);
        bus_read(CH_STATUS, r, r4);
        check("fullpop_empty4", r4, 16'h1000);

        bus_write(CH_CTRL, 16'h0003);
`ifdef FSMC_FIFO_IRQ_EN
        bus_write(CH_THRESH, 16'h0003);
        bus_read(CH_THRESH, r, r4);
        check("thresh_rb", r, 16'h0003);
        push(16'h0041);
        push(16'h0042);
        tick(); tick();
        check("irq_below", irq, 1'b0);
        push(16'h0043);
        tick(); tick();
        check("irq_rise", irq, 1'b1);
        check("irq_rise4", irq4, 1'b1);
        bus_read(CH_STATUS, r, r4);
        check("irq_status", r, 16'h0803);
        bus_read(CH_DATA, r, r4);
        check("irq_pop_data", r, 16'h0041);
        tick(); tick();
        check("irq_fall", irq, 1'b0);
`else
        bus_write(CH_THRESH, 16'h0003);
        bus_read(CH_THRESH, r, r4);
        check("thresh_rb_off", r, 16'h0000);
        for (int i = 1; i <= 3; i++) push(16'(16'h40 + i));
        tick(); tick();
        check("irq_off", irq, 1'b0);
        bus_read(CH_STATUS, r, r4);
        check("irq_off_status", r, 16'h0003);
`endif

        // Reset during a DATA read; the select drops right after reset.
        bus_cs = 4'b0001; bus_state = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_cs = '0;
        tick();
        tick();
        check("rst_mid_rdata", rdata, 16'h0000);
        check("rst_mid_irq", irq, 1'b0);
        bus_read(CH_STATUS, r, r4);
        check("rst_mid_status", r, 16'h1000);
        check("rst_mid_status4", r4, 16'h1000);
        bus_read(CH_CTRL, r, r4);
        check("rst_mid_ctrl", r, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsmc_sample_fifo.md
FSMC_SAMPLE_FIFO -- requirements
Module: fsmc_sample_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of samples and bus words.
REQ-002 SHALL have parameter DEPTH, default 256: FIFO depth; must be a power of two and 4..1024.
REQ-003 SHALL have parameter CS_WIDTH, default 2: width of the channel index; the block uses 4 channels.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port s_data, input, DATA_WIDTH bits: sample from the upstream ADC stage.
REQ-007 SHALL have port s_valid, input, 1 bit: sample strobe, one cycle per sample; no backpressure.
REQ-008 SHALL have port bus_cs, input, 2**CS_WIDTH bits: one-hot channel select from the FSMC interface stage.
REQ-009 SHALL have port bus_state, input, 1 bit: access direction; 1 = read, 0 = write.
REQ-010 SHALL have port bus_wdata, input, DATA_WIDTH bits: write data latched by the FSMC stage.
REQ-011 SHALL have port bus_rdata, output, DATA_WIDTH bits: word driven back to the FSMC stage.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-013 SHALL decode the channel map: bit 0 = DATA (read pops), bit 1 = STATUS (read-only), bit 2 = CTRL (read/write), bit 3 = THRESH (read/write).
REQ-014 SHALL treat a bus access as complete on the cycle any bus_cs bit is registered 1 and is now 0 (falling edge); bus_state is sampled on that cycle.
REQ-015 SHALL perform a write on access completion with bus_state=0, committing bus_wdata on that same cycle.
REQ-016 SHALL continuously drive bus_rdata, registered, from the currently asserted bus_cs bit; with no bus_cs bit asserted, bus_rdata SHALL be 0.
REQ-017 SHALL present on DATA the FIFO head, or 0 when the FIFO is empty.
REQ-018 SHALL pop on DATA read completion; the next head SHALL be visible on bus_rdata 1 cycle later.
REQ-019 SHALL format STATUS as: [15] overflow (sticky), [14] underflow (sticky), [13] full, [12] empty, [11] irq, [10:0] count (zero-extended).
REQ-020 SHALL format CTRL as: [0] enable, [1] clear; clear is write-1 and self-clearing and reads back 0.
REQ-021 SHALL accept a push when s_valid=1, enable=1 and the FIFO is not full; data is written at the tail.
REQ-022 SHALL drop the sample and set overflow when s_valid=1, enable=1 and the FIFO is full; with enable=0, s_valid SHALL be ignored with no flag change.
REQ-023 SHALL leave the FIFO unchanged and set underflow on a DATA pop while empty.
REQ-024 SHALL, on a simultaneous push and pop, leave count unchanged; if full, the push SHALL succeed because the pop frees the slot in the same cycle.
REQ-025 SHALL keep count in the range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-026 SHALL, on a clear write, flush count and pointers and clear overflow and underflow 1 cycle after completion; a push in that cycle SHALL be discarded.
REQ-027 SHALL NOT pop on any read of STATUS, CTRL or THRESH.

Reset
REQ-028 SHALL, while reset=1 at a clk edge, set count, pointers, overflow, underflow, enable, THRESH, bus_rdata and irq to 0, and clear the edge-detect history of bus_cs.
REQ-029 SHALL abandon any access in progress when reset is applied mid-access; a bus_cs falling edge in the first cycle after reset SHALL be ignored.

Configuration
REQ-030 SHALL, with FSMC_FIFO_IRQ_EN defined, assert irq while enable=1 and count >= THRESH, with THRESH != 0, registered with 1-cycle latency; THRESH SHALL be 11 bits read/write with bits above 10 reading 0.
REQ-031 SHALL, without FSMC_FIFO_IRQ_EN, tie irq to 0, make THRESH read 0 and ignore THRESH writes, and force STATUS[11] to 0.

Structure
REQ-032 SHALL take from shared package fsmc_pkg: channel index constants (CH_DATA, CH_STATUS, CH_CTRL, CH_THRESH), STATUS and CTRL bit positions, and the status word typedef.
REQ-033 SHALL instantiate one sub-module, sync_fifo_ram: dual-pointer RAM with registered head output and count; bus decode and flags stay in fsmc_sample_fifo.

Verification
REQ-034 SHALL cover fill and drain: enable=1, push 0x0001..0x0005 -> STATUS count=5; five DATA reads return 0x0001..0x0005 in order, then empty=1.
REQ-035 SHALL cover overflow: DEPTH=4, push 6 samples -> full=1, overflow=1, count=4; reads return the first 4 samples.
REQ-036 SHALL cover underflow: DATA read while empty -> returns 0x0000, underflow=1, count stays 0.
REQ-037 SHALL cover full with simultaneous push and pop: push 0xAAAA on the pop-completion cycle -> count stays DEPTH, overflow stays 0, and 0xAAAA is the last word read.
REQ-038 SHALL cover clear: with overflow=1 and count=3, write CTRL=0x0003 -> next STATUS reads count=0, empty=1, overflow=0, enable=1.
REQ-039 SHALL cover the interrupt with FSMC_FIFO_IRQ_EN defined: THRESH=3, push 3 samples -> irq rises 1 cycle after the third push and falls 1 cycle after the first pop.
